midi_transmitter: RTL and testbench

Serializes parsed MIDI channel messages into a 31250-baud MIDI/UART byte stream on a single output pin. It is the outbound counterpart of the MIDI receive path: it takes the same MIDI::message_t the parser produces and emits status plus 1 or 2 data bytes. Typical uses are MIDI-thru, sending parameter Control Change messages to an external controller, and loopback test of the receive chain. It sits between the synthesizer control logic and the board's MIDI OUT pin.

---
 rtl/midi_transmitter_pkg.sv | 37 +++
 rtl/midi_transmitter_tx_byte.sv | 64 ++++++
 rtl/midi_transmitter.sv | 113 +++++++++++
 tb/tb_midi_transmitter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_transmitter_pkg.sv
// Shared MIDI message definitions used by the receive parser and the transmit path.
package MIDI;

  typedef struct packed {
    logic [3:0] message_type;
    logic [3:0] channel;
    logic [7:0] data_byte1;
    logic [7:0] data_byte2;
  } message_t;

  localparam logic [3:0] NOTE_OFF         = 4'h8;
  localparam logic [3:0] NOTE_ON          = 4'h9;
  localparam logic [3:0] POLY_PRESSURE    = 4'hA;
  localparam logic [3:0] CONTROL_CHANGE   = 4'hB;
  localparam logic [3:0] PROGRAM_CHANGE   = 4'hC;
  localparam logic [3:0] CHANNEL_PRESSURE = 4'hD;
  localparam logic [3:0] PITCH_BEND       = 4'hE;
  localparam logic [3:0] SYSTEM           = 4'hF;

  localparam int CLKS_PER_BIT_31250 = 1600;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LOAD,
    TX_SEND
  } tx_state_e;

  // Zero marks a type this path cannot transmit (system and non-status nibbles).
  function automatic logic [1:0] data_byte_count(input logic [3:0] message_type);
    case (message_type)
      NOTE_OFF, NOTE_ON, POLY_PRESSURE, CONTROL_CHANGE, PITCH_BEND: data_byte_count = 2'd2;
      PROGRAM_CHANGE, CHANNEL_PRESSURE:                            data_byte_count = 2'd1;
      default:                                                     data_byte_count = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/midi_transmitter_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 1600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_start,
  output logic       tx,
  output logic       busy,
  output logic       byte_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic [9:0]    frame_q, frame_d;
  logic          busy_q, busy_d;

  // byte_done marks the final cycle of the stop bit, so a byte_start issued
  // in that cycle puts the next start bit directly behind the stop bit.
  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    frame_d   = frame_q;
    busy_d    = busy_q;
    byte_done = busy_q && (cnt_q == CNT_LAST) && (idx_q == 4'd9);
    if (busy_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        if (idx_q == 4'd9) busy_d = 1'b0;
        else               idx_d  = idx_q + 4'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    if (byte_start) begin
      frame_d = {1'b1, byte_in, 1'b0};
      busy_d  = 1'b1;
      cnt_d   = '0;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      frame_q <= '1;
      busy_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
    end
  end

  assign tx   = busy_q ? frame_q[idx_q] : 1'b1;
  assign busy = busy_q;

endmodule

// File: rtl/midi_transmitter.sv
// MIDI OUT: turns a parsed channel message into status + data bytes on a 31250-baud line.
module midi_transmitter
  import MIDI::*;
#(
  parameter int CLKS_PER_BIT   = CLKS_PER_BIT_31250,
  parameter bit RUNNING_STATUS = 1'b1
) (
  input  logic     clock_50_000_000,
  input  logic     reset,
  input  message_t message,
  input  logic     message_valid,
  output logic     tx_ready,
  output logic     message_done,
  output logic     message_error,
  output logic     midi_tx
);

  tx_state_e       state_q, state_d;
  logic [2:0][7:0] bytes_q, bytes_d;
  logic [1:0]      last_idx_q, last_idx_d;
  logic [1:0]      byte_index_q, byte_index_d;
  logic [7:0]      last_status_q, last_status_d;
  logic            message_error_q, message_error_d;

  logic [7:0] status;
  logic [1:0] count;
  logic [1:0] next_index;
  logic       skip_status, last_done, offer, accept;
  logic [7:0] ser_byte;
  logic       ser_start, ser_busy, ser_done;

  assign status      = {message.message_type, message.channel};
  assign count       = data_byte_count(message.message_type);
  assign next_index  = byte_index_q + 2'd1;
  // last_status resets to 0x00, which never matches a real status byte.
  assign skip_status = RUNNING_STATUS && (status == last_status_q);
  assign last_done   = (state_q == TX_SEND) && ser_done && (byte_index_q == last_idx_q);
  assign tx_ready    = ((state_q == TX_IDLE) && !ser_busy) || last_done;
  assign offer       = message_valid && tx_ready;
  assign accept      = offer && (count != 2'd0);

  always_comb begin
    state_d         = state_q;
    bytes_d         = bytes_q;
    last_idx_d      = last_idx_q;
    byte_index_d    = byte_index_q;
    last_status_d   = last_status_q;
    message_error_d = offer && (count == 2'd0);
    ser_start       = 1'b0;
    ser_byte        = (next_index == 2'd1) ? bytes_q[1] : bytes_q[2];

    case (state_q)
      TX_LOAD: state_d = TX_SEND;
      TX_SEND: begin
        if (ser_done) begin
          if (byte_index_q == last_idx_q) begin
            state_d = TX_IDLE;
          end else begin
            byte_index_d = next_index;
            ser_start    = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // The first byte goes to the serializer on the accept edge itself so the
    // start bit appears one cycle later; LOAD is just the settling step.
    if (accept) begin
      bytes_d[0]   = status;
      bytes_d[1]   = message.data_byte1 & 8'h7F;
      bytes_d[2]   = message.data_byte2 & 8'h7F;
      last_idx_d   = count;
      byte_index_d = skip_status ? 2'd1 : 2'd0;
      ser_byte     = skip_status ? (message.data_byte1 & 8'h7F) : status;
      ser_start    = 1'b1;
      state_d      = TX_LOAD;
      if (!skip_status) last_status_d = status;
    end
  end

  always_ff @(posedge clock_50_000_000) begin
    if (reset) begin
      state_q         <= TX_IDLE;
      bytes_q         <= '0;
      last_idx_q      <= '0;
      byte_index_q    <= '0;
      last_status_q   <= 8'h00;
      message_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      bytes_q         <= bytes_d;
      last_idx_q      <= last_idx_d;
      byte_index_q    <= byte_index_d;
      last_status_q   <= last_status_d;
      message_error_q <= message_error_d;
    end
  end

  assign message_done  = last_done;
  assign message_error = message_error_q;

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_byte (
    .clk       (clock_50_000_000),
    .reset     (reset),
    .byte_in   (ser_byte),
    .byte_start(ser_start),
    .tx        (midi_tx),
    .busy      (ser_busy),
    .byte_done (ser_done)
  );

endmodule

// File: tb/tb_midi_transmitter.sv
// Directed bench for midi_transmitter: UART line decoder plus per-scenario checks.
module tb_midi_transmitter;
  import MIDI::*;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  message_t   message = '0;
  logic [1:0] vld = 2'b00;
  logic [1:0] rdy, done, err, tx;
  int         cyc = 0;
  int         compared = 0, mismatched = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  midi_transmitter #(.CLKS_PER_BIT(CPB), .RUNNING_STATUS(1'b1)) dut (
    .clock_50_000_000(clk), .reset(reset), .message(message), .message_valid(vld[0]),
    .tx_ready(rdy[0]), .message_done(done[0]), .message_error(err[0]), .midi_tx(tx[0]));

  midi_transmitter #(.CLKS_PER_BIT(CPB), .RUNNING_STATUS(1'b0)) dut_nors (
    .clock_50_000_000(clk), .reset(reset), .message(message), .message_valid(vld[1]),
    .tx_ready(rdy[1]), .message_done(done[1]), .message_error(err[1]), .midi_tx(tx[1]));

  // Line decoders: sample each bit in its middle, record start-bit cycle.
  logic [7:0] rxq0[$], rxq1[$];
  int         stq0[$];
  int         done_cnt0 = 0, done_cnt1 = 0, fe = 0;

  task automatic rx_frame(input int k, output logic [7:0] b, output int st);
    st = cyc;
    repeat (CPB / 2) @(negedge clk);
    if (tx[k] !== 1'b0) fe++;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = tx[k];
    end
    repeat (CPB) @(negedge clk);
    if (tx[k] !== 1'b1) fe++;
  endtask

  always begin : mon0
    logic [7:0] b;
    int st;
    @(negedge clk);
    if (!reset && tx[0] === 1'b0) begin
      rx_frame(0, b, st);
      rxq0.push_back(b);
      stq0.push_back(st);
    end
  end

  always begin : mon1
    logic [7:0] b;
    int st;
    @(negedge clk);
    if (!reset && tx[1] === 1'b0) begin
      rx_frame(1, b, st);
      rxq1.push_back(b);
    end
  end

  always @(negedge clk) begin
    if (done[0] === 1'b1) done_cnt0++;
    if (done[1] === 1'b1) done_cnt1++;
  end

  // Holds message_valid until tx_ready is seen; acc is the first start-bit cycle.
  task automatic send(input int k, input message_t m, output int acc, output logic done_at_acc);
    int n = 0;
    @(negedge clk);
    message = m;
    vld[k]  = 1'b1;
    while (rdy[k] !== 1'b1 && n < 80 * CPB) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (rdy[k] !== 1'b1) begin
      mismatched++;
      $display("FAIL send_wait_ready dut%0d: tx_ready=%b, required 1", k, rdy[k]);
    end
    done_at_acc = done[k];
    acc = cyc + 1;
    @(negedge clk);
    vld[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, output int dc);
    dc = -1;
    for (int n = 0; n < 80 * CPB; n++) begin
      @(negedge clk);
      if (done[k] === 1'b1) begin
        dc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    compared += 4;
    if (tx[0] !== 1'b1)   begin mismatched++; $display("FAIL reset_midi_tx: got %b, required 1", tx[0]); end
    if (rdy[0] !== 1'b1)  begin mismatched++; $display("FAIL reset_tx_ready: got %b, required 1", rdy[0]); end
    if (done[0] !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b, required 0", done[0]); end
    if (err[0] !== 1'b0)  begin mismatched++; $display("FAIL reset_error: got %b, required 0", err[0]); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_note_on();
    logic [7:0] exp[$] = '{8'h90, 8'h3C, 8'h64};
    logic [7:0] got;
    int acc, dc;
    logic d;
    rxq0.delete(); stq0.delete();
    send(0, {NOTE_ON, 4'h0, 8'h3C, 8'h64}, acc, d);
    wait_done(0, dc);
    compared += 2;
    if (dc - acc + 1 !== 30 * CPB) begin mismatched++; $display("FAIL note_on_span: got %0d cycles, required %0d", dc - acc + 1, 30 * CPB); end
    if (rdy[0] !== 1'b1) begin mismatched++; $display("FAIL note_on_ready_at_done: got %b, required 1", rdy[0]); end
    repeat (CPB) @(negedge clk);
    compared++;
    if (rxq0.size() !== 3) begin mismatched++; $display("FAIL note_on_count: got %0d bytes, required 3", rxq0.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < rxq0.size()) ? rxq0[i] : 8'hxx;
      compared++;
      if (got !== exp[i]) begin mismatched++; $display("FAIL note_on_byte%0d: got %h, required %h", i, got, exp[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (i >= stq0.size() || stq0[i] !== acc + 10 * CPB * i) begin
        mismatched++;
        $display("FAIL note_on_start%0d: got %0d, required %0d", i, (i < stq0.size()) ? stq0[i] : -1, acc + 10 * CPB * i);
      end
    end
  endtask

  task automatic test_program_change();
    logic [7:0] exp[$] = '{8'hC3, 8'h05};
    logic [7:0] got;
    int acc, dc;
    logic d;
    rxq0.delete(); stq0.delete();
    send(0, {PROGRAM_CHANGE, 4'h3, 8'h05, 8'h00}, acc, d);
    wait_done(0, dc);
    compared += 2;
    if (dc - acc + 1 !== 20 * CPB) begin mismatched++; $display("FAIL pc_span: got %0d cycles, required %0d", dc - acc + 1, 20 * CPB); end
    if (rdy[0] !== 1'b1) begin mismatched++; $display("FAIL pc_ready_at_done: got %b, required 1", rdy[0]); end
    repeat (CPB) @(negedge clk);
    compared++;
    if (rxq0.size() !== 2) begin mismatched++; $display("FAIL pc_count: got %0d bytes, required 2", rxq0.size()); end
    for (int i = 0; i < 2; i++) begin
      got = (i < rxq0.size()) ? rxq0[i] : 8'hxx;
      compared++;
      if (got !== exp[i]) begin mismatched++; $display("FAIL pc_byte%0d: got %h, required %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[$] = '{8'hB0, 8'h07, 8'h7F, 8'h07, 8'h00};
    logic [7:0] got;
    int acc1, acc2, dc;
    logic d1, d2;
    rxq0.delete(); stq0.delete();
    send(0, {CONTROL_CHANGE, 4'h0, 8'h07, 8'h7F}, acc1, d1);
    send(0, {CONTROL_CHANGE, 4'h0, 8'h07, 8'h00}, acc2, d2);
    compared += 2;
    if (d2 !== 1'b1) begin mismatched++; $display("FAIL b2b_accept_in_done: done=%b at accept, required 1", d2); end
    if (acc2 !== acc1 + 30 * CPB) begin mismatched++; $display("FAIL b2b_gap: second start %0d, required %0d", acc2, acc1 + 30 * CPB); end
    wait_done(0, dc);
    compared++;
    if (dc - acc2 + 1 !== 20 * CPB) begin mismatched++; $display("FAIL b2b_span: got %0d cycles, required %0d", dc - acc2 + 1, 20 * CPB); end
    repeat (CPB) @(negedge clk);
    compared += 2;
    if (rxq0.size() !== 5) begin mismatched++; $display("FAIL b2b_count: got %0d bytes, required 5", rxq0.size()); end
    if (stq0.size() < 4 || stq0[3] !== acc2) begin mismatched++; $display("FAIL b2b_rs_start: second message start not at %0d", acc2); end
    for (int i = 0; i < 5; i++) begin
      got = (i < rxq0.size()) ? rxq0[i] : 8'hxx;
      compared++;
      if (got !== exp[i]) begin mismatched++; $display("FAIL b2b_byte%0d: got %h, required %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_no_running_status();
    logic [7:0] exp[$] = '{8'hB0, 8'h07, 8'h7F, 8'hB0, 8'h07, 8'h00};
    logic [7:0] got;
    int acc1, acc2, dc;
    logic d1, d2;
    rxq1.delete();
    send(1, {CONTROL_CHANGE, 4'h0, 8'h07, 8'h7F}, acc1, d1);
    send(1, {CONTROL_CHANGE, 4'h0, 8'h07, 8'h00}, acc2, d2);
    wait_done(1, dc);
    compared += 2;
    if (acc2 !== acc1 + 30 * CPB) begin mismatched++; $display("FAIL nors_gap: second start %0d, required %0d", acc2, acc1 + 30 * CPB); end
    if (dc - acc2 + 1 !== 30 * CPB) begin mismatched++; $display("FAIL nors_span: got %0d cycles, required %0d", dc - acc2 + 1, 30 * CPB); end
    repeat (CPB) @(negedge clk);
    compared++;
    if (rxq1.size() !== 6) begin mismatched++; $display("FAIL nors_count: got %0d bytes, required 6", rxq1.size()); end
    for (int i = 0; i < 6; i++) begin
      got = (i < rxq1.size()) ? rxq1[i] : 8'hxx;
      compared++;
      if (got !== exp[i]) begin mismatched++; $display("FAIL nors_byte%0d: got %h, required %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_unsupported();
    logic [7:0] exp[$] = '{8'h07, 8'h10, 8'h80, 8'h40, 8'h00};
    logic [7:0] got;
    int c0, bad, acc, dc;
    logic d;
    rxq0.delete();
    c0 = done_cnt0;
    @(negedge clk);
    message = {SYSTEM, 4'h0, 8'h01, 8'h02};
    vld[0]  = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    compared++;
    if (err[0] !== 1'b1) begin mismatched++; $display("FAIL err_pulse: got %b, required 1", err[0]); end
    @(negedge clk);
    compared++;
    if (err[0] !== 1'b0) begin mismatched++; $display("FAIL err_pulse_width: got %b, required 0", err[0]); end
    bad = 0;
    for (int i = 0; i < 3 * CPB; i++) begin
      if (tx[0] !== 1'b1 || rdy[0] !== 1'b1) bad++;
      @(negedge clk);
    end
    compared += 3;
    if (bad !== 0) begin mismatched++; $display("FAIL err_line_idle: %0d cycles not idle/ready, required 0", bad); end
    if (done_cnt0 !== c0) begin mismatched++; $display("FAIL err_no_done: got %0d done pulses, required 0", done_cnt0 - c0); end
    if (rxq0.size() !== 0) begin mismatched++; $display("FAIL err_no_bytes: got %0d bytes, required 0", rxq0.size()); end
    // last_status still 0xB0: the CC skips its status, the Note Off sends its own.
    send(0, {CONTROL_CHANGE, 4'h0, 8'h07, 8'h10}, acc, d);
    wait_done(0, dc);
    send(0, {NOTE_OFF, 4'h0, 8'h40, 8'h00}, acc, d);
    wait_done(0, dc);
    repeat (CPB) @(negedge clk);
    compared++;
    if (rxq0.size() !== 5) begin mismatched++; $display("FAIL err_after_count: got %0d bytes, required 5", rxq0.size()); end
    for (int i = 0; i < 5; i++) begin
      got = (i < rxq0.size()) ? rxq0[i] : 8'hxx;
      compared++;
      if (got !== exp[i]) begin mismatched++; $display("FAIL err_after_byte%0d: got %h, required %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_mask_ignore();
    logic [7:0] exp[$] = '{8'hB1, 8'h7F, 8'h00};
    logic [7:0] got;
    int c0, acc, dc;
    logic d;
    rxq0.delete();
    c0 = done_cnt0;
    send(0, {CONTROL_CHANGE, 4'h1, 8'hFF, 8'h80}, acc, d);
    repeat (3 * CPB) @(negedge clk);
    compared++;
    if (rdy[0] !== 1'b0) begin mismatched++; $display("FAIL busy_ready: got %b, required 0", rdy[0]); end
    message = {NOTE_ON, 4'h2, 8'h11, 8'h22};
    vld[0]  = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    wait_done(0, dc);
    repeat (5 * CPB) @(negedge clk);
    compared += 3;
    if (done_cnt0 !== c0 + 1) begin mismatched++; $display("FAIL ignore_done: got %0d done pulses, required 1", done_cnt0 - c0); end
    if (rdy[0] !== 1'b1) begin mismatched++; $display("FAIL ignore_ready: got %b, required 1", rdy[0]); end
    if (rxq0.size() !== 3) begin mismatched++; $display("FAIL mask_count: got %0d bytes, required 3", rxq0.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < rxq0.size()) ? rxq0[i] : 8'hxx;
      compared++;
      if (got !== exp[i]) begin mismatched++; $display("FAIL mask_byte%0d: got %h, required %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] exp[$] = '{8'hB1, 8'h01, 8'h02};
    logic [7:0] got;
    int c0, acc, dc;
    logic d;
    // last_status is 0xB1 here, so before the reset this would skip its status.
    send(0, {CONTROL_CHANGE, 4'h1, 8'h01, 8'h02}, acc, d);
    repeat (49) @(negedge clk);
    c0 = done_cnt0;
    reset = 1'b1;
    @(negedge clk);
    compared += 2;
    if (tx[0] !== 1'b1)  begin mismatched++; $display("FAIL abort_midi_tx: got %b, required 1", tx[0]); end
    if (rdy[0] !== 1'b1) begin mismatched++; $display("FAIL abort_ready: got %b, required 1", rdy[0]); end
    reset = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    compared++;
    if (done_cnt0 !== c0) begin mismatched++; $display("FAIL abort_no_done: got %0d done pulses, required 0", done_cnt0 - c0); end
    rxq0.delete(); stq0.delete();
    send(0, {CONTROL_CHANGE, 4'h1, 8'h01, 8'h02}, acc, d);
    wait_done(0, dc);
    repeat (CPB) @(negedge clk);
    compared += 2;
    if (rxq0.size() !== 3) begin mismatched++; $display("FAIL abort_resend_count: got %0d bytes, required 3", rxq0.size()); end
    if (stq0.size() < 1 || stq0[0] !== acc) begin mismatched++; $display("FAIL abort_resend_latency: start not at %0d", acc); end
    for (int i = 0; i < 3; i++) begin
      got = (i < rxq0.size()) ? rxq0[i] : 8'hxx;
      compared++;
      if (got !== exp[i]) begin mismatched++; $display("FAIL abort_resend_byte%0d: got %h, required %h", i, got, exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_program_change();
    test_back_to_back();
    test_no_running_status();
    test_unsupported();
    test_mask_ignore();
    test_reset_midframe();
    compared++;
    if (fe !== 0) begin mismatched++; $display("FAIL framing: %0d bad start/stop bits, required 0", fe); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
